// File: rtl/stim_compare_ctrl_if.sv
// Stimulus/compare bus between the equivalence controller and its environment
// (run control, shared stimulus, the two observed outputs and the run statistics).
interface stim_compare_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned VC_W  = 16,
  parameter int unsigned MM_W  = 16
);
  logic             start;
  logic             dut_rst;
  logic [WIDTH-1:0] in_vec;
  logic [WIDTH-1:0] golden_out;
  logic [WIDTH-1:0] netlist_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [VC_W-1:0]  vec_cnt;
  logic [MM_W-1:0]  mismatch_cnt;
  logic             first_mm_valid;
  logic [VC_W-1:0]  first_mm_idx;
  logic [WIDTH-1:0] first_mm_golden;
  logic [WIDTH-1:0] first_mm_netlist;

  modport master (
    input  start, golden_out, netlist_out,
    output dut_rst, in_vec, busy, done, pass, vec_cnt, mismatch_cnt,
           first_mm_valid, first_mm_idx, first_mm_golden, first_mm_netlist
  );

  modport slave (
    output start, golden_out, netlist_out,
    input  dut_rst, in_vec, busy, done, pass, vec_cnt, mismatch_cnt,
           first_mm_valid, first_mm_idx, first_mm_golden, first_mm_netlist
  );
endinterface

// File: rtl/stim_compare_ctrl.sv
// Equivalence-run engine: drives LFSR stimulus and a DUT reset to a golden and a
// post-route instance, compares their outputs after a settle time, keeps statistics.
module stim_compare_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_VECTORS = 1000,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned RST_CYCLES  = 2,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int unsigned VC_W        = 16,
  parameter int unsigned MM_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  stim_compare_ctrl_if.master bus
);

  localparam logic [31:0]     SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]     TAPS     = 32'h8020_0003;
  localparam logic [VC_W-1:0] LAST_IDX = VC_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {IDLE, DUTRST, APPLY, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      lfsr, lfsr_nxt;
  logic [31:0]      phase_cnt;
  logic             phase_last;
  logic             armed;
  logic             take_start;
  logic             mismatch;
  logic [WIDTH-1:0] in_vec_q;
  logic [VC_W-1:0]  vec_cnt_q, first_idx_q;
  logic [MM_W-1:0]  mm_cnt_q;
  logic             first_valid_q;
  logic [WIDTH-1:0] first_gold_q, first_net_q;

  // armed blocks a start that coincides with the reset-release edge
  always_comb begin
    lfsr_nxt   = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    take_start = bus.start && armed && (state == IDLE || state == DONE);
    phase_last = (state == DUTRST) ? (phase_cnt == 32'(RST_CYCLES - 1))
                                   : (phase_cnt == 32'(SETTLE - 1));
    mismatch   = (bus.golden_out !== bus.netlist_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (take_start) state_nxt = DUTRST;
      DUTRST:     if (phase_last) state_nxt = APPLY;
      APPLY:      state_nxt = WAIT;
      WAIT:       if (phase_last) state_nxt = (vec_cnt_q == LAST_IDX) ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed         <= 1'b0;
      lfsr          <= SEED_EFF;
      phase_cnt     <= '0;
      in_vec_q      <= '0;
      vec_cnt_q     <= '0;
      mm_cnt_q      <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      first_gold_q  <= '0;
      first_net_q   <= '0;
    end else begin
      armed <= 1'b1;
      if (take_start) begin
        lfsr          <= SEED_EFF;
        phase_cnt     <= '0;
        in_vec_q      <= '0;
        vec_cnt_q     <= '0;
        mm_cnt_q      <= '0;
        first_valid_q <= 1'b0;
        first_idx_q   <= '0;
        first_gold_q  <= '0;
        first_net_q   <= '0;
      end else begin
        case (state)
          DUTRST: phase_cnt <= phase_last ? '0 : phase_cnt + 32'd1;
          APPLY: begin
            lfsr      <= lfsr_nxt;
            in_vec_q  <= lfsr_nxt[WIDTH-1:0];
            phase_cnt <= '0;
          end
          WAIT: begin
            if (phase_last) begin
              phase_cnt <= '0;
              vec_cnt_q <= vec_cnt_q + 1'b1;
              if (mismatch) begin
                if (mm_cnt_q != '1) mm_cnt_q <= mm_cnt_q + 1'b1;
                if (!first_valid_q) begin
                  first_valid_q <= 1'b1;
                  first_idx_q   <= vec_cnt_q;
                  first_gold_q  <= bus.golden_out;
                  first_net_q   <= bus.netlist_out;
                end
              end
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.dut_rst          = (state == IDLE) || (state == DUTRST);
    bus.busy             = (state == DUTRST) || (state == APPLY) || (state == WAIT);
    bus.done             = (state == DONE);
    bus.pass             = (state == DONE) && (mm_cnt_q == '0);
    bus.in_vec           = in_vec_q;
    bus.vec_cnt          = vec_cnt_q;
    bus.mismatch_cnt     = mm_cnt_q;
    bus.first_mm_valid   = first_valid_q;
    bus.first_mm_idx     = first_idx_q;
    bus.first_mm_golden  = first_gold_q;
    bus.first_mm_netlist = first_net_q;
  end

endmodule

// File: tb/tb_stim_compare_ctrl.sv
// Directed bench for stim_compare_ctrl: three instances cover the matched run,
// sparse mismatches and counter saturation.
module tb_stim_compare_ctrl;

  localparam logic [31:0] K = 32'hA5A5_1234;

  logic clk;
  logic rst_a, rst_bc;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] seq [8];

  stim_compare_ctrl_if #(.WIDTH(32), .VC_W(16), .MM_W(16)) bus_a ();
  stim_compare_ctrl_if #(.WIDTH(32), .VC_W(16), .MM_W(16)) bus_b ();
  stim_compare_ctrl_if #(.WIDTH(32), .VC_W(16), .MM_W(4))  bus_c ();

  stim_compare_ctrl #(.WIDTH(32), .NUM_VECTORS(4), .SETTLE(2), .RST_CYCLES(2),
    .SEED(32'h1), .VC_W(16), .MM_W(16)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
  stim_compare_ctrl #(.WIDTH(32), .NUM_VECTORS(8), .SETTLE(2), .RST_CYCLES(2),
    .SEED(32'h1), .VC_W(16), .MM_W(16)) u_b (.clk(clk), .rst(rst_bc), .bus(bus_b.master));
  stim_compare_ctrl #(.WIDTH(32), .NUM_VECTORS(20), .SETTLE(2), .RST_CYCLES(2),
    .SEED(32'h1), .VC_W(16), .MM_W(4)) u_c (.clk(clk), .rst(rst_bc), .bus(bus_c.master));

  // Golden instance modelled as a fixed XOR; netlist variants per instance
  assign bus_a.golden_out  = bus_a.in_vec ^ K;
  assign bus_a.netlist_out = bus_a.golden_out;
  assign bus_b.golden_out  = bus_b.in_vec ^ K;
  assign bus_b.netlist_out = bus_b.golden_out ^
         {31'd0, (bus_b.in_vec == seq[2]) || (bus_b.in_vec == seq[5])};
  assign bus_c.golden_out  = bus_c.in_vec ^ K;
  assign bus_c.netlist_out = ~bus_c.golden_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 8; i++) begin
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
      seq[i] = s;
    end
    rst_a = 1'b0; rst_bc = 1'b0;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    #1;
    check("rst_dut_rst",  bus_a.dut_rst, 1);
    check("rst_in_vec",   bus_a.in_vec, 0);
    check("rst_busy",     bus_a.busy, 0);
    check("rst_done",     bus_a.done, 0);
    check("rst_pass",     bus_a.pass, 0);
    check("rst_vec_cnt",  bus_a.vec_cnt, 0);
    check("rst_mm_cnt",   bus_a.mismatch_cnt, 0);
    check("rst_first_v",  bus_a.first_mm_valid, 0);

    @(negedge clk); rst_a = 1'b1; rst_bc = 1'b1;
    repeat (2) @(negedge clk);

    // Run A: start edge is E0
    bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    check("e0_busy",    bus_a.busy, 1);
    check("e0_dut_rst", bus_a.dut_rst, 1);
    check("e0_in_vec",  bus_a.in_vec, 0);
    tick();
    check("e1_dut_rst", bus_a.dut_rst, 1);
    tick();
    check("e2_dut_rst", bus_a.dut_rst, 0);
    check("e2_in_vec",  bus_a.in_vec, 0);
    tick();
    check("e3_vec0", bus_a.in_vec, 32'h8020_0003);
    tick();
    check("e4_vec0", bus_a.in_vec, 32'h8020_0003);
    tick();
    check("e5_vec0", bus_a.in_vec, 32'h8020_0003);
    tick();
    check("e6_vec1", bus_a.in_vec, 32'hC030_0002);
    @(negedge clk); bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    check("busy_start_busy", bus_a.busy, 1);
    check("busy_start_vec",  bus_a.in_vec, 32'hC030_0002);
    repeat (6) tick();
    check("e13_done", bus_a.done, 0);
    tick();
    check("e14_done",    bus_a.done, 1);
    check("a_pass",      bus_a.pass, 1);
    check("a_busy",      bus_a.busy, 0);
    check("a_dut_rst",   bus_a.dut_rst, 0);
    check("a_vec_cnt",   bus_a.vec_cnt, 4);
    check("a_mm_cnt",    bus_a.mismatch_cnt, 0);
    check("a_first_v",   bus_a.first_mm_valid, 0);
    check("a_last_vec",  bus_a.in_vec, 32'hB02C_0003);

    // Restart from DONE, then abort with reset during WAIT of vector 3
    @(negedge clk); bus_a.start = 1'b1; tick(); bus_a.start = 1'b0;
    check("r_vec_cnt", bus_a.vec_cnt, 0);
    check("r_done",    bus_a.done, 0);
    check("r_pass",    bus_a.pass, 0);
    check("r_busy",    bus_a.busy, 1);
    check("r_in_vec",  bus_a.in_vec, 0);
    repeat (3) tick();
    check("r_vec0", bus_a.in_vec, 32'h8020_0003);
    repeat (3) tick();
    check("r_vec1", bus_a.in_vec, 32'hC030_0002);
    repeat (6) tick();
    check("r_vec3",     bus_a.in_vec, 32'hB02C_0003);
    check("r_vec_cnt3", bus_a.vec_cnt, 3);
    #3 rst_a = 1'b0;
    #1;
    check("abort_dut_rst", bus_a.dut_rst, 1);
    check("abort_in_vec",  bus_a.in_vec, 0);
    check("abort_busy",    bus_a.busy, 0);
    check("abort_vec_cnt", bus_a.vec_cnt, 0);
    @(negedge clk); rst_a = 1'b1;
    repeat (5) tick();
    check("idle_busy",    bus_a.busy, 0);
    check("idle_done",    bus_a.done, 0);
    check("idle_dut_rst", bus_a.dut_rst, 1);
    check("idle_in_vec",  bus_a.in_vec, 0);

    // Runs B and C in parallel
    @(negedge clk); bus_b.start = 1'b1; bus_c.start = 1'b1;
    tick(); bus_b.start = 1'b0; bus_c.start = 1'b0;
    for (int i = 0; i < 200 && !(bus_b.done && bus_c.done); i++) tick();
    check("b_done",      bus_b.done, 1);
    check("c_done",      bus_c.done, 1);
    check("b_vec_cnt",   bus_b.vec_cnt, 8);
    check("b_mm_cnt",    bus_b.mismatch_cnt, 2);
    check("b_pass",      bus_b.pass, 0);
    check("b_first_v",   bus_b.first_mm_valid, 1);
    check("b_first_idx", bus_b.first_mm_idx, 2);
    check("b_first_g",   bus_b.first_mm_golden, 32'hC5BD_1235);
    check("b_first_n",   bus_b.first_mm_netlist, 32'hC5BD_1234);
    check("c_vec_cnt",   bus_c.vec_cnt, 20);
    check("c_mm_sat",    bus_c.mismatch_cnt, 4'hF);
    check("c_pass",      bus_c.pass, 0);
    check("c_first_idx", bus_c.first_mm_idx, 0);
    check("c_first_g",   bus_c.first_mm_golden, 32'h2585_1237);
    check("c_first_n",   bus_c.first_mm_netlist, 32'hDA7A_EDC8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stim_compare_ctrl.md
Name: stim_compare_ctrl

Overview:
- Self-checking stimulus/compare engine for post-route equivalence runs; sits upstream and downstream of a golden RTL instance and its post-route netlist instance.
- Drives a shared pseudo-random input vector and a DUT reset to both instances.
- Waits a fixed settle time after each vector, compares the two outputs, and accumulates mismatch statistics.
- Reports pass/fail after a fixed number of vectors.

Parameters:
- WIDTH, 32, stimulus/output width (1..32); in_vec is the low WIDTH bits of the 32-bit LFSR.
- NUM_VECTORS, 1000, vectors applied per run (>=1).
- SETTLE, 2, cycles between applying a vector and sampling outputs (>=1).
- RST_CYCLES, 2, cycles dut_rst is held after start (>=1).
- SEED, 32'h0000_0001, LFSR seed; value 0 is replaced by 1.
- VC_W, 16, width of vec_cnt and first_mm_idx.
- MM_W, 16, width of mismatch_cnt (saturating).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request.
- dut_rst  out  1  active-high reset to both DUT instances.
- in_vec  out  WIDTH  stimulus to both DUT instances.
- golden_out  in  WIDTH  golden instance output.
- netlist_out  in  WIDTH  post-route instance output.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  valid when done; 1 iff mismatch_cnt==0.
- vec_cnt  out  VC_W  vectors compared so far.
- mismatch_cnt  out  MM_W  mismatching compares, saturating at all-ones.
- first_mm_valid  out  1  a first mismatch has been captured.
- first_mm_idx  out  VC_W  vector index (0-based) of the first mismatch.
- first_mm_golden  out  WIDTH  golden_out at the first mismatch.
- first_mm_netlist  out  WIDTH  netlist_out at the first mismatch.

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - State IDLE; dut_rst=1; in_vec=0; busy=0; done=0; pass=0.
  - All counters and first_mm_* outputs are 0; LFSR=SEED (0 becomes 1).
  - Reset mid-run aborts the run with no partial results kept.
- LFSR: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0). Advances only in APPLY.
- FSM:
  - IDLE: start=1 -> DUTRST. On entry, clear counters, first_mm_*, done and pass; load LFSR=SEED; set busy=1.
  - DUTRST: dut_rst=1, in_vec=0 for RST_CYCLES cycles -> APPLY. dut_rst deasserts on the edge leaving DUTRST.
  - APPLY (1 cycle): at its closing edge, in_vec<=next(s)[WIDTH-1:0] and s<=next(s) -> WAIT.
  - WAIT (SETTLE cycles): at the closing edge of the last WAIT cycle, sample and compare, increment vec_cnt, update mismatch stats.
    - If the new vec_cnt==NUM_VECTORS -> DONE, else -> APPLY.
  - DONE: busy=0; done=1; pass=(mismatch_cnt==0); dut_rst=0; in_vec holds its last value. start=1 -> restart exactly as from IDLE.
- Vector period is 1+SETTLE cycles. Compare uses 4-state inequality: any X/Z difference counts as a mismatch.
- First mismatch: captured only while first_mm_valid=0; later mismatches do not overwrite it.
- mismatch_cnt saturates at 2^MM_W-1; vec_cnt keeps counting.
- start while busy is ignored. start asserted on the same edge rst deasserts is ignored.

Test Plan:
- SEED=1, WIDTH=32: first two applied in_vec values are 32'h8020_0003, then 32'hC030_0002 -> exactly these, each held 1+SETTLE cycles.
- NUM_VECTORS=4, SETTLE=2, RST_CYCLES=2, netlist_out tied to golden_out, start pulse -> done=1, pass=1, vec_cnt=4, mismatch_cnt=0, first_mm_valid=0; done rises 2+4*3=14 edges after the start edge.
- NUM_VECTORS=8, netlist_out=golden_out^1 during vector index 2 and index 5 only -> mismatch_cnt=2, pass=0, first_mm_idx=2, first_mm_netlist=first_mm_golden^1.
- MM_W=4, NUM_VECTORS=20, netlist_out=~golden_out always -> mismatch_cnt=15 (saturated), vec_cnt=20, pass=0, first_mm_idx=0.
- rst driven low between clock edges during WAIT of vector 3 -> immediately dut_rst=1, in_vec=0, busy=0, vec_cnt=0. After release with no start, state stays IDLE.
- start pulsed while busy -> no effect. start pulsed in DONE -> counters clear and the second run reproduces an identical in_vec sequence starting at 32'h8020_0003.
